keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Upstream stage of the alarm-clock controller. Scans a 4x3 matrix keypad, synchronises and debounces the row inputs, and presents the held key as a 4-bit code.
- `key` holds the digit 0-9 while the key is held. It returns to NOKEY (10) after a debounced release, which gives the controller its press / wait-for-release sequencing.

Parameters:
- DEBOUNCE_TICKS, 4: consecutive matching scan_tick samples required to accept a press and, separately, a release. Legal range 1..15.
- NOKEY, 10: code driven on `key` when no key is accepted.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: asynchronous, active-high.
- scan_tick  input  1  one-clk scan enable pulse, at about 1 kHz.
- row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous.
- col_n  output  3  column drive, active-low, one-cold.
- key  output  4  accepted key code, or NOKEY.
- key_strobe  output  1  one-clk pulse when a new key is accepted.

Behaviour:
- Key layout:
  - row0: 1 2 3
  - row1: 4 5 6
  - row2: 7 8 9
  - row3: * 0 #
  - col0 is the left column.
- Synchronisation: row_n passes through a 2-flop synchroniser (row_s). All decisions use row_s, sampled only on cycles where scan_tick=1.
- Reset values: state=SCAN, col_n=3'b110, key=NOKEY, key_strobe=0, debounce count=0, synchroniser flops=4'b1111.
- States: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN (on scan_tick):
  - Exactly one bit of row_s low and it maps to a valid key: latch row/col into the candidate, count=1, go to PRESS_DB, col_n frozen.
  - Otherwise, including zero or two or more rows low: rotate col_n 110->101->011->110.
- PRESS_DB (on scan_tick):
  - Same single row low: count+1.
  - When count reaches DEBOUNCE_TICKS: key<=decoded code, key_strobe=1 for that clk, go to HELD.
  - Any other row pattern: count=0, go to SCAN, col_n rotates.
  - If DEBOUNCE_TICKS=1, the transition goes straight SCAN->HELD on the first sample and asserts the strobe.
- HELD (on scan_tick):
  - row_s=4'b1111: count=1, go to RELEASE_DB.
  - Otherwise, stay. `key` stays stable and no further strobes are issued. Auto-repeat is not supported.
- RELEASE_DB (on scan_tick):
  - row_s=4'b1111: count+1. When count reaches DEBOUNCE_TICKS: key<=NOKEY, go to SCAN, col_n rotates on the same tick.
  - Any row low: count=0, return to HELD. `key` is unchanged and there is no strobe.
- Column freeze: col_n never changes outside SCAN, or outside the exit tick from PRESS_DB / RELEASE_DB to SCAN.
- Outputs are registered. Latency from a stable press at the pins: 2 clk synchroniser, plus DEBOUNCE_TICKS scan_ticks after the column is first driven, plus 1 clk to `key`.
- A second key pressed while HELD is ignored until a full debounced release.
- Reset asserted mid-operation forces all reset values immediately, asynchronously. No strobe is produced.
- The count saturates and never wraps.
- A scan_tick held high for more than one clk is treated as one sample per clk. The source guarantees a one-clk pulse.

Optional Feature:
- Macro: KEYPAD_STAR_HASH_EN.
- Defined: `*` decodes to 4'd11 and `#` to 4'd12, with full press/hold/release handling and a strobe.
- Undefined: row3/col0 and row3/col2 are not valid keys. SCAN treats them like no press, and key stays NOKEY.

Test Plan:
- Hold row1 low while col1 is driven (key `5`), DEBOUNCE_TICKS=4, then release:
  - key=5 on the 4th matching tick plus 1 clk.
  - key_strobe high for exactly 1 clk.
  - key=NOKEY 4 ticks after release.
- Press `0` (row3, col1) with bounce: low for 2 ticks, high for 1, then stable low:
  - No accept during the bounce.
  - Accept after 4 stable ticks, key=0.
  - Single strobe.
- Release bounce in HELD for key `9`: high for 2 ticks, low for 1, then stable high:
  - key stays 9 through the glitch.
  - key=NOKEY after 4 clean ticks.
  - No extra strobe.
- Rows 0 and 2 low together in col0: no state change, col_n keeps rotating, key=10.
- Press `*`:
  - With KEYPAD_STAR_HASH_EN: key=11 plus strobe.
  - Without: key stays 10 and col_n keeps rotating.
- Assert rst while in HELD with key=3: key=10, col_n=110 and key_strobe=0 immediately. After rst deasserts, scanning resumes from col0.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x3 matrix keypad, debounces the rows and encodes the held key; define KEYPAD_STAR_HASH_EN to decode * as 11 and # as 12
module keypad_scanner #(
  parameter int         DEBOUNCE_TICKS = 4,
  parameter logic [3:0] NOKEY          = 4'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_tick,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [3:0] key,
  output logic       key_strobe
);
  localparam logic [3:0] DB = 4'(DEBOUNCE_TICKS);
  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;
  state_t state, next_state;
  logic [3:0] row_m, row_s, cand, next_cand, cand_key, next_cand_key;
  logic [3:0] cnt, next_cnt, cnt_inc, next_key, code;
  logic [2:0] next_col, col_rot;
  logic [1:0] r, c;
  logic one_low, valid, done, next_strobe;
  assign one_low = row_s inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
  assign r = !row_s[0] ? 2'd0 : !row_s[1] ? 2'd1 : !row_s[2] ? 2'd2 : 2'd3;
  assign c = !col_n[0] ? 2'd0 : !col_n[1] ? 2'd1 : 2'd2;
  assign code = r == 2'd3 ? (c == 2'd1 ? 4'd0 : c == 2'd0 ? 4'd11 : 4'd12)
                          : {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
`ifdef KEYPAD_STAR_HASH_EN
  assign valid = one_low;
`else
  assign valid = one_low && (r != 2'd3 || c == 2'd1);
`endif
  assign col_rot = {col_n[1:0], col_n[2]};
  assign cnt_inc = cnt == 4'hf ? cnt : cnt + 4'd1;
  assign done = cnt_inc >= DB;
  // synchroniser, FSM state and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row_m <= 4'hf;
      row_s <= 4'hf;
      state <= SCAN;
      cnt <= 4'd0;
      col_n <= 3'b110;
      key <= NOKEY;
      key_strobe <= 1'b0;
      cand <= 4'hf;
      cand_key <= NOKEY;
    end else begin
      row_m <= row_n;
      row_s <= row_m;
      state <= next_state;
      cnt <= next_cnt;
      col_n <= next_col;
      key <= next_key;
      key_strobe <= next_strobe;
      cand <= next_cand;
      cand_key <= next_cand_key;
    end
  // scan/debounce decisions, taken only on scan_tick; count returns to 0 on every state change so cnt_inc starts at 1
  always_comb begin
    next_state = state;
    next_cnt = cnt;
    next_col = col_n;
    next_key = key;
    next_strobe = 1'b0;
    next_cand = cand;
    next_cand_key = cand_key;
    if (scan_tick)
      case (state)
        SCAN:
          if (valid) begin
            next_cand = row_s;
            next_cand_key = code;
            next_cnt = done ? 4'd0 : cnt_inc;
            next_state = done ? HELD : PRESS_DB;
            next_key = done ? code : key;
            next_strobe = done;
          end else
            next_col = col_rot;
        PRESS_DB:
          if (row_s == cand) begin
            next_cnt = done ? 4'd0 : cnt_inc;
            next_state = done ? HELD : PRESS_DB;
            next_key = done ? cand_key : key;
            next_strobe = done;
          end else begin
            next_cnt = 4'd0;
            next_state = SCAN;
            next_col = col_rot;
          end
        HELD, RELEASE_DB:
          if (row_s == 4'hf) begin
            next_cnt = done ? 4'd0 : cnt_inc;
            next_state = done ? SCAN : RELEASE_DB;
            next_key = done ? NOKEY : key;
            next_col = done ? col_rot : col_n;
          end else begin
            next_cnt = 4'd0;
            next_state = HELD;
          end
      endcase
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model plus behavioural reference checked every clock
module tb_keypad_scanner;
  localparam int DB = 4;
`ifdef KEYPAD_STAR_HASH_EN
  localparam int STAR = 11;
  localparam int HASH = 12;
`else
  localparam int STAR = -1;
  localparam int HASH = -1;
`endif
  logic clk = 1'b0, rst = 1'b1, scan_tick = 1'b0, key_strobe;
  logic [3:0] row_n, key, rn;
  logic [2:0] col_n;
  logic [11:0] pressed = '0;
  int layout [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{STAR, 0, HASH}};
  int passed = 0, total = 0, strobes = 0;
  int m_mode = 0, m_col = 0, m_run = 0, m_key = 10, m_code = 10;
  bit m_strobe = 1'b0;
  logic [3:0] m_s1 = 4'hf, m_s2 = 4'hf, m_cand = 4'hf;

  keypad_scanner dut (.clk(clk), .rst(rst), .scan_tick(scan_tick), .row_n(row_n),
                      .col_n(col_n), .key(key), .key_strobe(key_strobe));

  always #5 clk = ~clk;

  // physical matrix: a row is pulled low by any pressed key in the driven column
  always_comb begin
    row_n = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && col_n[c] === 1'b0) row_n[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_tick();
    int zeros = 0, r = 0, code = -1;
    for (int i = 0; i < 4; i++) if (!m_s2[i]) begin zeros++; r = i; end
    if (zeros == 1) code = layout[r][m_col];
    case (m_mode)
      0: if (code >= 0) begin
           m_cand = m_s2; m_code = code; m_run = 1;
           if (m_run >= DB) begin m_key = m_code; m_strobe = 1'b1; m_mode = 2; end else m_mode = 1;
         end else m_col = (m_col + 1) % 3;
      1: if (m_s2 == m_cand) begin
           m_run++;
           if (m_run >= DB) begin m_key = m_code; m_strobe = 1'b1; m_mode = 2; end
         end else begin m_mode = 0; m_col = (m_col + 1) % 3; end
      2: if (m_s2 == 4'hf) begin
           m_run = 1;
           if (m_run >= DB) begin m_key = 10; m_mode = 0; m_col = (m_col + 1) % 3; end else m_mode = 3;
         end
      default: if (m_s2 == 4'hf) begin
           m_run++;
           if (m_run >= DB) begin m_key = 10; m_mode = 0; m_col = (m_col + 1) % 3; end
         end else m_mode = 2;
    endcase
  endtask

  task automatic cyc(input bit tick);
    logic [2:0] ecol;
    scan_tick = tick;
    #1 rn = row_n;
    @(posedge clk);
    m_strobe = 1'b0;
    if (tick) model_tick();
    m_s2 = m_s1;
    m_s1 = rn;
    #1 ecol = ~(3'b001 << m_col);
    chk("key", {4'b0, key}, 8'(m_key));
    chk("strobe", {7'b0, key_strobe}, {7'b0, m_strobe});
    chk("col", {5'b0, col_n}, {5'b0, ecol});
    if (key_strobe) strobes++;
    @(negedge clk);
  endtask

  task automatic run_ticks(input int n, input int per);
    for (int i = 0; i < n; i++) begin
      repeat (per - 1) cyc(1'b0);
      cyc(1'b1);
    end
  endtask

  task automatic wait_key(input string tag, input int code, input int budget);
    for (int i = 0; i < budget && key !== 4'(code); i++) run_ticks(1, 4);
    chk(tag, {4'b0, key}, 8'(code));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_key", {4'b0, key}, 8'd10);
    chk("rst_col", {5'b0, col_n}, 8'b110);
    chk("rst_strobe", {7'b0, key_strobe}, 8'd0);
    rst = 1'b0;
    run_ticks(4, 4);
    // key 5, clean press then release
    strobes = 0;
    pressed = 12'b1 << 4;
    wait_key("press5", 5, 40);
    run_ticks(5, 4);
    chk("hold5_key", {4'b0, key}, 8'd5);
    chk("strobes5", 8'(strobes), 8'd1);
    pressed = '0;
    run_ticks(DB - 1, 4);
    chk("rel5_pending", {4'b0, key}, 8'd5);
    run_ticks(1, 4);
    chk("rel5", {4'b0, key}, 8'd10);
    // key 0 with a press bounce
    strobes = 0;
    pressed = 12'b1 << 10;
    for (int i = 0; i < 40 && m_mode != 1; i++) run_ticks(1, 4);
    run_ticks(1, 4);
    pressed = '0;
    run_ticks(1, 4);
    chk("bounce0_key", {4'b0, key}, 8'd10);
    chk("bounce0_strobes", 8'(strobes), 8'd0);
    pressed = 12'b1 << 10;
    wait_key("press0", 0, 40);
    chk("strobes0", 8'(strobes), 8'd1);
    pressed = '0;
    wait_key("rel0", 10, 20);
    // key 9 with a release bounce
    strobes = 0;
    pressed = 12'b1 << 8;
    wait_key("press9", 9, 40);
    pressed = '0;
    run_ticks(2, 4);
    pressed = 12'b1 << 8;
    run_ticks(1, 4);
    chk("glitch9", {4'b0, key}, 8'd9);
    pressed = '0;
    run_ticks(DB - 1, 4);
    chk("rel9_pending", {4'b0, key}, 8'd9);
    run_ticks(1, 4);
    chk("rel9", {4'b0, key}, 8'd10);
    chk("strobes9", 8'(strobes), 8'd1);
    // rows 0 and 2 together in col0
    strobes = 0;
    pressed = (12'b1 << 0) | (12'b1 << 6);
    run_ticks(15, 4);
    chk("two_rows_key", {4'b0, key}, 8'd10);
    chk("two_rows_strobes", 8'(strobes), 8'd0);
    pressed = '0;
    run_ticks(2, 4);
    // star key
    strobes = 0;
    pressed = 12'b1 << 9;
    run_ticks(15, 4);
    chk("star_key", {4'b0, key}, STAR < 0 ? 8'd10 : 8'(STAR));
    chk("star_strobes", 8'(strobes), STAR < 0 ? 8'd0 : 8'd1);
    pressed = '0;
    wait_key("star_rel", 10, 20);
    // reset while holding 3
    pressed = 12'b1 << 2;
    wait_key("press3", 3, 40);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_key", {4'b0, key}, 8'd10);
    chk("mid_rst_col", {5'b0, col_n}, 8'b110);
    chk("mid_rst_strobe", {7'b0, key_strobe}, 8'd0);
    pressed = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_mode = 0; m_col = 0; m_run = 0; m_key = 10; m_strobe = 1'b0; m_s1 = 4'hf; m_s2 = 4'hf;
    run_ticks(3, 4);
    // random keys, multi-key chords and tick spacing
    for (int it = 0; it < 40; it++) begin
      int kind;
      kind = $urandom_range(0, 3);
      pressed = kind == 0 ? 12'b0 : 12'b1 << $urandom_range(0, 11);
      if (kind == 3) pressed = pressed | (12'b1 << $urandom_range(0, 11));
      run_ticks($urandom_range(1, 12), $urandom_range(2, 5));
    end
    pressed = '0;
    run_ticks(8, 4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
